// File: rtl/fetch_basic_if.sv
// Fetch unit channels: instruction-memory request/response, fetch-to-decode val/rdy, execute redirect.
// master = fetch unit side, slave = memory/decode/execute environment side.
interface fetch_basic_if #(
  parameter int p_addr_bits = 32,
  parameter int p_inst_bits = 32
);
  logic                   mem_req_val;
  logic                   mem_req_rdy;
  logic [p_addr_bits-1:0] mem_req_addr;
  logic                   mem_resp_val;
  logic                   mem_resp_rdy;
  logic [p_inst_bits-1:0] mem_resp_data;
  logic                   D_val;
  logic                   D_rdy;
  logic [p_inst_bits-1:0] D_inst;
  logic [p_addr_bits-1:0] D_pc;
  logic                   squash;
  logic [p_addr_bits-1:0] branch_target;

  modport master (
    output mem_req_val, mem_req_addr, mem_resp_rdy, D_val, D_inst, D_pc,
    input  mem_req_rdy, mem_resp_val, mem_resp_data, D_rdy, squash, branch_target
  );

  modport slave (
    input  mem_req_val, mem_req_addr, mem_resp_rdy, D_val, D_inst, D_pc,
    output mem_req_rdy, mem_resp_val, mem_resp_data, D_rdy, squash, branch_target
  );
endinterface

// File: rtl/fetch_basic.sv
// In-order single-issue fetch: sequential PC requests, p_depth-entry buffer to decode, squash redirect.
// Latency: response in cycle N is visible to decode in N+1; requests stall while buffered+in-flight reaches p_depth.
// FETCH_BASIC_PERF_EN adds perf_fetched/perf_dropped counters.
module fetch_basic #(
  parameter int                     p_addr_bits = 32,
  parameter int                     p_inst_bits = 32,
  parameter int                     p_depth     = 2,
  parameter logic [p_addr_bits-1:0] p_rst_addr  = 'h200
) (
  input  logic         clk,
  input  logic         rst,
  fetch_basic_if.master bus
`ifdef FETCH_BASIC_PERF_EN
  ,
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_dropped
`endif
);

  localparam int ptr_w = $clog2(p_depth);
  localparam int cnt_w = $clog2(p_depth + 1);
  localparam logic [cnt_w:0] depth_c = (cnt_w + 1)'(p_depth);

  logic [p_addr_bits-1:0] pc_reg;
  logic [p_addr_bits-1:0] ent_pc   [p_depth];
  logic [p_inst_bits-1:0] ent_inst [p_depth];
  logic [p_depth-1:0]     ent_filled;
  logic [ptr_w-1:0]       head;
  logic [ptr_w-1:0]       tail;
  logic [ptr_w-1:0]       fill;
  logic [cnt_w-1:0]       occ;
  logic [cnt_w-1:0]       drop_cnt;
  logic [cnt_w-1:0]       filled_cnt;
  logic [cnt_w-1:0]       unfilled;
  logic                   has_room;
  logic                   req_xfer;
  logic                   resp_xfer;
  logic                   resp_keep;
  logic                   deq;

  always_comb begin
    filled_cnt = '0;
    for (int i = 0; i < p_depth; i++) begin
      filled_cnt = filled_cnt + cnt_w'(ent_filled[i]);
    end
  end

  // Allocated entries still waiting on memory; these become drops on squash.
  assign unfilled  = occ - filled_cnt;
  assign has_room  = ({1'b0, occ} + {1'b0, drop_cnt}) < depth_c;

  assign bus.mem_req_val  = !rst && !bus.squash && has_room;
  assign bus.mem_req_addr = pc_reg;
  assign bus.mem_resp_rdy = !rst;
  assign bus.D_val        = !rst && !bus.squash && ent_filled[head];
  assign bus.D_inst       = ent_inst[head];
  assign bus.D_pc         = ent_pc[head];

  assign req_xfer  = bus.mem_req_val && bus.mem_req_rdy;
  assign resp_xfer = bus.mem_resp_val && bus.mem_resp_rdy;
  assign resp_keep = resp_xfer && (drop_cnt == '0);
  assign deq       = bus.D_val && bus.D_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg     <= p_rst_addr;
      ent_filled <= '0;
      head       <= '0;
      tail       <= '0;
      fill       <= '0;
      occ        <= '0;
      drop_cnt   <= '0;
    end else if (bus.squash) begin
      // Every unfilled entry still has a response coming; one may be arriving right now.
      pc_reg     <= bus.branch_target;
      ent_filled <= '0;
      head       <= '0;
      tail       <= '0;
      fill       <= '0;
      occ        <= '0;
      drop_cnt   <= drop_cnt + unfilled - cnt_w'(resp_xfer);
    end else begin
      if (deq) begin
        ent_filled[head] <= 1'b0;
        head             <= head + ptr_w'(1);
      end
      if (resp_xfer) begin
        if (drop_cnt != '0) begin
          drop_cnt <= drop_cnt - cnt_w'(1);
        end else begin
          ent_filled[fill] <= 1'b1;
          fill             <= fill + ptr_w'(1);
        end
      end
      if (req_xfer) begin
        ent_filled[tail] <= 1'b0;
        tail             <= tail + ptr_w'(1);
        pc_reg           <= pc_reg + p_addr_bits'(4);
      end
      occ <= occ + cnt_w'(req_xfer) - cnt_w'(deq);
    end
  end

  // Payload storage needs no reset: the filled bits qualify it.
  always_ff @(posedge clk) begin
    if (req_xfer) begin
      ent_pc[tail] <= pc_reg;
    end
    if (!rst && !bus.squash && resp_keep) begin
      ent_inst[fill] <= bus.mem_resp_data;
    end
  end

`ifdef FETCH_BASIC_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else if (bus.squash) begin
      perf_dropped <= perf_dropped + 32'(filled_cnt) + 32'(resp_xfer);
    end else begin
      if (deq) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (resp_xfer && (drop_cnt != '0)) begin
        perf_dropped <= perf_dropped + 32'd1;
      end
    end
  end
`endif

  a_outstanding_bound: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, occ} + {1'b0, drop_cnt}) <= depth_c);

  a_resp_expected: assert property (@(posedge clk) disable iff (rst)
    resp_xfer |-> (drop_cnt != '0) || (unfilled != '0));

endmodule
